// File: rtl/riscv8_pkg.sv
// Shared definitions for the 8-bit RISC-V pipeline.
// Holds opcode constants, ALU op-class encodings and the 9-bit control
// bundle layout used by the IF/ID, ID/EX and EX/MEM stages, plus helpers
// that decide which source registers an instruction actually reads.
package riscv8_pkg;

    // Major opcodes
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // ALU op classes produced by the control decoder
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OP_JAL   = 2'b11;

    localparam int unsigned CTRL_W = 9;

    // Control bundle, MSB first: valid, branch, mem_read, mem_to_reg,
    // mem_write, alu_src, reg_write, alu_op[1:0]
    typedef struct packed {
        logic       valid;
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] alu_op;
    } ctrl_t;

    // jal ignores its rs1 field
    function automatic logic uses_rs1(input logic [1:0] alu_op);
        return alu_op != ALU_OP_JAL;
    endfunction

    // rs2 is read by register-register ops and by stores (store data)
    function automatic logic uses_rs2(input logic alu_src, input logic mem_write);
        return ~alu_src | mem_write;
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector (purely combinational).
// Ports:
//   id_valid, id_rs1, id_rs2    decode-slot validity and source indices
//   use_rs1, use_rs2            whether the decode instruction reads rs1/rs2
//   ex_valid, ex_mem_read, ex_rd  registered EX-stage load information
//   haz_c                       load in EX writes a register ID needs now
module hazard_detect #(
    parameter int unsigned REG_W = 5
) (
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             use_rs1,
    input  logic             use_rs2,
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    output logic             haz_c
);

    logic load_in_ex_c;
    logic rs1_hit_c;
    logic rs2_hit_c;

    // x0 is never a real destination, so a load to x0 cannot cause a hazard
    assign load_in_ex_c = ex_valid & ex_mem_read & (ex_rd != REG_W'(0));
    assign rs1_hit_c    = use_rs1 & (ex_rd == id_rs1);
    assign rs2_hit_c    = use_rs2 & (ex_rd == id_rs2);
    assign haz_c        = id_valid & load_in_ex_c & (rs1_hit_c | rs2_hit_c);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard handling.
// Captures decoded controls, operands and register indices into EX. On a
// load-use hazard it inserts a bubble and raises stall so fetch/decode hold;
// on flush it squashes the wrong-path ID instruction. bubble_cnt counts
// hazard bubbles (saturating) for performance debug.
// Ports:
//   clk, reset            clock, async active-high reset
//   id_*                  decode-stage controls, operands, indices
//   flush                 taken branch/jal in EX, ID slot is wrong-path
//   cnt_clr               synchronous clear of bubble_cnt
//   ex_*, ex_valid        registered EX-stage copies
//   stall                 combinational freeze request for PC and IF/ID
//   bubble_cnt            saturating hazard-bubble count
module id_ex_stage
    import riscv8_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic              id_branch,
    input  logic              id_mem_read,
    input  logic              id_mem_to_reg,
    input  logic              id_mem_write,
    input  logic              id_alu_src,
    input  logic              id_reg_write,
    input  logic [1:0]        id_alu_op,
    input  logic [DATA_W-1:0] id_rs1_data,
    input  logic [DATA_W-1:0] id_rs2_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [3:0]        id_funct,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic              ex_valid,
    output logic              ex_branch,
    output logic              ex_mem_read,
    output logic              ex_mem_to_reg,
    output logic              ex_mem_write,
    output logic              ex_alu_src,
    output logic              ex_reg_write,
    output logic [1:0]        ex_alu_op,
    output logic [DATA_W-1:0] ex_rs1_data,
    output logic [DATA_W-1:0] ex_rs2_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc,
    output logic [REG_W-1:0]  ex_rs1,
    output logic [REG_W-1:0]  ex_rs2,
    output logic [REG_W-1:0]  ex_rd,
    output logic [3:0]        ex_funct,
    output logic              stall,
    output logic [7:0]        bubble_cnt
);

    localparam int unsigned CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ctrl_t             ctrl_q;
    ctrl_t             id_ctrl_c;
    logic              haz_c;
    logic [DATA_W-1:0] rs1_data_q;
    logic [DATA_W-1:0] rs2_data_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] pc_q;
    logic [REG_W-1:0]  rs1_q;
    logic [REG_W-1:0]  rs2_q;
    logic [REG_W-1:0]  rd_q;
    logic [3:0]        funct_q;
    logic [CNT_W-1:0]  cnt_q;

    hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard_detect (
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .use_rs1     (uses_rs1(id_alu_op)),
        .use_rs2     (uses_rs2(id_alu_src, id_mem_write)),
        .ex_valid    (ctrl_q.valid),
        .ex_mem_read (ctrl_q.mem_read),
        .ex_rd       (rd_q),
        .haz_c       (haz_c)
    );

    // A flush already kills the ID instruction, so no freeze is needed
    assign stall = haz_c & ~flush;

    // Decode controls, zeroed for an empty slot; if-form maps x on mem_to_reg to 0
    always_comb begin
        id_ctrl_c = '0;
        if (id_valid) begin
            id_ctrl_c.valid     = 1'b1;
            id_ctrl_c.branch    = id_branch;
            id_ctrl_c.mem_read  = id_mem_read;
            id_ctrl_c.mem_write = id_mem_write;
            id_ctrl_c.alu_src   = id_alu_src;
            id_ctrl_c.reg_write = id_reg_write;
            id_ctrl_c.alu_op    = id_alu_op;
            if (id_mem_to_reg) begin
                id_ctrl_c.mem_to_reg = 1'b1;
            end
        end
    end

    // Pipeline register: flush or hazard inserts a bubble, data fields hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q     <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            funct_q    <= '0;
        end else if (flush | haz_c) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q     <= id_ctrl_c;
            rs1_data_q <= id_rs1_data;
            rs2_data_q <= id_rs2_data;
            imm_q      <= id_imm;
            pc_q       <= id_pc;
            rs1_q      <= id_rs1;
            rs2_q      <= id_rs2;
            rd_q       <= id_rd;
            funct_q    <= id_funct;
        end
    end

    // Saturating bubble counter; clear beats increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (stall && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign ex_valid      = ctrl_q.valid;
    assign ex_branch     = ctrl_q.branch;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_alu_src    = ctrl_q.alu_src;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_alu_op     = ctrl_q.alu_op;
    assign ex_rs1_data   = rs1_data_q;
    assign ex_rs2_data   = rs2_data_q;
    assign ex_imm        = imm_q;
    assign ex_pc         = pc_q;
    assign ex_rs1        = rs1_q;
    assign ex_rs2        = rs2_q;
    assign ex_rd         = rd_q;
    assign ex_funct      = funct_q;
    assign bubble_cnt    = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized self-checking bench for id_ex_stage with a behavioural model.
module tb_id_ex_stage;

    typedef struct packed {
        logic       valid;
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] alu_op;
        logic [7:0] rs1_data;
        logic [7:0] rs2_data;
        logic [7:0] imm;
        logic [7:0] pc;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [3:0] funct;
    } instr_t;

    logic       clk, reset;
    logic       id_valid, id_branch, id_mem_read, id_mem_to_reg, id_mem_write;
    logic       id_alu_src, id_reg_write;
    logic [1:0] id_alu_op;
    logic [7:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic [3:0] id_funct;
    logic       flush, cnt_clr;
    logic       ex_valid, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write;
    logic       ex_alu_src, ex_reg_write;
    logic [1:0] ex_alu_op;
    logic [7:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic [3:0] ex_funct;
    logic       stall;
    logic [7:0] bubble_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: what the EX slot should hold, and the bubble count
    instr_t m_ex;
    int     m_cnt;
    bit     m_stall;
    instr_t cur;
    logic   cur_fl, cur_clr;

    id_ex_stage #(.DATA_W(8), .REG_W(5)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_branch(id_branch), .id_mem_read(id_mem_read),
        .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write),
        .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_alu_op(id_alu_op),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_funct(id_funct), .flush(flush), .cnt_clr(cnt_clr),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_mem_read(ex_mem_read),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write),
        .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write), .ex_alu_op(ex_alu_op),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_funct(ex_funct), .stall(stall), .bubble_cnt(bubble_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Does the ID instruction need the register a load in EX is about to write?
    function automatic bit model_haz(input instr_t id);
        bit reads_rs1, reads_rs2;
        reads_rs1 = (id.alu_op != 2'b11);
        reads_rs2 = !id.alu_src || id.mem_write;
        if (!id.valid || !m_ex.valid || !m_ex.mem_read || m_ex.rd == 5'd0) return 1'b0;
        return (reads_rs1 && id.rs1 == m_ex.rd) || (reads_rs2 && id.rs2 == m_ex.rd);
    endfunction

    function automatic instr_t base();
        instr_t i;
        i = '0;
        i.valid    = 1'b1;
        i.rs1_data = 8'($urandom);
        i.rs2_data = 8'($urandom);
        i.imm      = 8'($urandom);
        i.pc       = 8'($urandom);
        i.funct    = 4'($urandom);
        i.rd       = 5'($urandom);
        i.rs1      = 5'($urandom);
        i.rs2      = 5'($urandom);
        return i;
    endfunction

    function automatic instr_t mk_ld(input logic [4:0] rd, input logic [4:0] rs1);
        instr_t i;
        i = base();
        i.mem_read = 1'b1; i.mem_to_reg = 1'b1; i.alu_src = 1'b1; i.reg_write = 1'b1;
        i.alu_op = 2'b00; i.rd = rd; i.rs1 = rs1;
        return i;
    endfunction

    function automatic instr_t mk_alu(input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic imm_form);
        instr_t i;
        i = base();
        i.reg_write = 1'b1; i.alu_src = imm_form; i.alu_op = 2'b10;
        i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
        return i;
    endfunction

    function automatic instr_t mk_sd(input logic [4:0] rs1, input logic [4:0] rs2);
        instr_t i;
        i = base();
        i.mem_write = 1'b1; i.alu_src = 1'b1; i.alu_op = 2'b00;
        i.rs1 = rs1; i.rs2 = rs2;
        return i;
    endfunction

    function automatic instr_t mk_jal(input logic [4:0] rd, input logic [4:0] rs1);
        instr_t i;
        i = base();
        i.branch = 1'b1; i.reg_write = 1'b1; i.alu_src = 1'b1; i.alu_op = 2'b11;
        i.rd = rd; i.rs1 = rs1;
        return i;
    endfunction

    // Random slot biased to a small register set so hazards are frequent
    function automatic instr_t mk_rand();
        instr_t i;
        i = base();
        i.valid      = ($urandom_range(0, 4) != 0);
        i.branch     = 1'($urandom);
        i.mem_read   = 1'($urandom);
        i.mem_to_reg = 1'($urandom);
        i.mem_write  = 1'($urandom);
        i.alu_src    = 1'($urandom);
        i.reg_write  = 1'($urandom);
        i.alu_op     = 2'($urandom);
        i.rd         = 5'($urandom_range(0, 7));
        i.rs1        = 5'($urandom_range(0, 7));
        i.rs2        = 5'($urandom_range(0, 7));
        return i;
    endfunction

    task automatic compare_all();
        check("ex_valid",      32'(ex_valid),      32'(m_ex.valid));
        check("ex_branch",     32'(ex_branch),     32'(m_ex.branch));
        check("ex_mem_read",   32'(ex_mem_read),   32'(m_ex.mem_read));
        check("ex_mem_to_reg", 32'(ex_mem_to_reg), 32'(m_ex.mem_to_reg));
        check("ex_mem_write",  32'(ex_mem_write),  32'(m_ex.mem_write));
        check("ex_alu_src",    32'(ex_alu_src),    32'(m_ex.alu_src));
        check("ex_reg_write",  32'(ex_reg_write),  32'(m_ex.reg_write));
        check("ex_alu_op",     32'(ex_alu_op),     32'(m_ex.alu_op));
        check("ex_rs1_data",   32'(ex_rs1_data),   32'(m_ex.rs1_data));
        check("ex_rs2_data",   32'(ex_rs2_data),   32'(m_ex.rs2_data));
        check("ex_imm",        32'(ex_imm),        32'(m_ex.imm));
        check("ex_pc",         32'(ex_pc),         32'(m_ex.pc));
        check("ex_rs1",        32'(ex_rs1),        32'(m_ex.rs1));
        check("ex_rs2",        32'(ex_rs2),        32'(m_ex.rs2));
        check("ex_rd",         32'(ex_rd),         32'(m_ex.rd));
        check("ex_funct",      32'(ex_funct),      32'(m_ex.funct));
        check("bubble_cnt",    32'(bubble_cnt),    32'(m_cnt));
    endtask

    // Present an ID slot and check the same-cycle stall
    task automatic apply(input instr_t i, input logic fl, input logic clr);
        cur = i; cur_fl = fl; cur_clr = clr;
        id_valid = i.valid; id_branch = i.branch; id_mem_read = i.mem_read;
        id_mem_to_reg = i.mem_to_reg; id_mem_write = i.mem_write;
        id_alu_src = i.alu_src; id_reg_write = i.reg_write; id_alu_op = i.alu_op;
        id_rs1_data = i.rs1_data; id_rs2_data = i.rs2_data; id_imm = i.imm;
        id_pc = i.pc; id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rd; id_funct = i.funct;
        flush = fl; cnt_clr = clr;
        #1;
        m_stall = model_haz(i) && !fl;
        check("stall", 32'(stall), 32'(m_stall));
    endtask

    // Clock edge: advance the model, then compare every registered output
    task automatic tick();
        bit bubble;
        @(posedge clk);
        bubble = cur_fl || model_haz(cur);
        if (cur_clr) m_cnt = 0;
        else if (m_stall && m_cnt < 255) m_cnt++;
        if (bubble) begin
            m_ex.valid = 0; m_ex.branch = 0; m_ex.mem_read = 0; m_ex.mem_to_reg = 0;
            m_ex.mem_write = 0; m_ex.alu_src = 0; m_ex.reg_write = 0; m_ex.alu_op = 2'b00;
        end else begin
            m_ex = cur;
            if (!cur.valid) begin
                m_ex.branch = 0; m_ex.mem_read = 0; m_ex.mem_to_reg = 0;
                m_ex.mem_write = 0; m_ex.alu_src = 0; m_ex.reg_write = 0; m_ex.alu_op = 2'b00;
            end
        end
        #1;
        compare_all();
    endtask

    initial begin
        instr_t i, ld5;
        bit     hold;

        m_ex = '0; m_cnt = 0;
        reset = 1'b1;
        apply(mk_jal(0, 0), 1'b0, 1'b0);
        compare_all();
        @(negedge clk);
        reset = 1'b0;

        // ld x5 followed by a dependent add: one bubble, then the add loads
        apply(mk_ld(5, 1), 0, 0); tick();
        i = mk_alu(3, 5, 2, 1'b0);
        apply(i, 0, 0);
        check("ld_use_stall", 32'(stall), 32'd1);
        tick();
        check("bubble_valid", 32'(ex_valid), 32'd0);
        check("bubble_cnt_1", 32'(bubble_cnt), 32'd1);
        apply(i, 0, 0);
        check("reissue_stall", 32'(stall), 32'd0);
        tick();
        check("add_reg_write", 32'(ex_reg_write), 32'd1);
        check("add_alu_op", 32'(ex_alu_op), 32'd2);

        // Load to x0 never stalls
        apply(mk_ld(0, 1), 0, 0); tick();
        apply(mk_alu(4, 0, 0, 1'b0), 0, 0);
        check("x0_no_stall", 32'(stall), 32'd0);
        tick();

        // addi ignores rs2; sd reads rs2 as store data
        apply(mk_ld(5, 1), 0, 0); tick();
        apply(mk_alu(6, 1, 5, 1'b1), 0, 0);
        check("addi_no_stall", 32'(stall), 32'd0);
        tick();
        apply(mk_ld(5, 1), 0, 0); tick();
        i = mk_sd(2, 5);
        apply(i, 0, 0);
        check("sd_stall", 32'(stall), 32'd1);
        tick();
        apply(i, 0, 0); tick();

        // jal does not read rs1
        apply(mk_ld(7, 1), 0, 0); tick();
        apply(mk_jal(1, 7), 0, 0);
        check("jal_no_stall", 32'(stall), 32'd0);
        tick();

        // Flush coincident with a hazard: no stall, bubble, counter unchanged
        apply(mk_ld(5, 1), 0, 0); tick();
        apply(mk_alu(3, 5, 5, 1'b0), 1'b1, 1'b0);
        check("flush_stall", 32'(stall), 32'd0);
        tick();
        check("flush_valid", 32'(ex_valid), 32'd0);
        check("flush_cnt", 32'(bubble_cnt), 32'd2);

        // 256 hazards: ld x5,(x5) back to back alternates stall / load
        ld5 = mk_ld(5, 5);
        apply(ld5, 0, 0); tick();
        for (int k = 0; k < 256; k++) begin
            apply(ld5, 0, 0); tick();
            apply(ld5, 0, 0); tick();
        end
        check("sat_cnt", 32'(bubble_cnt), 32'd255);
        apply(ld5, 0, 1'b1);
        check("clr_haz_stall", 32'(stall), 32'd1);
        tick();
        check("clr_cnt", 32'(bubble_cnt), 32'd0);
        apply(ld5, 0, 0); tick();

        // Build up 5 bubbles with a load in EX, then reset mid-stall
        for (int k = 0; k < 5; k++) begin
            apply(ld5, 0, 0); tick();
            apply(ld5, 0, 0); tick();
        end
        check("pre_reset_cnt", 32'(bubble_cnt), 32'd5);
        check("pre_reset_valid", 32'(ex_valid), 32'd1);
        apply(mk_alu(3, 5, 1, 1'b0), 0, 0);
        check("pre_reset_stall", 32'(stall), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        m_ex = '0; m_cnt = 0;
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_cnt", 32'(bubble_cnt), 32'd0);
        compare_all();
        @(negedge clk);
        reset = 1'b0;

        // Random traffic; upstream holds the ID slot while stalled
        hold = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if (!hold) i = mk_rand();
            apply(i, 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 29) == 0));
            hold = m_stall;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
